// File: rtl/mask_share_encoder_if.sv
// Share-encoder handshake bundle: seed, unmasked input and share output channels.
// The slave modport is the encoder side; master is whoever feeds and drains it.
interface mask_share_encoder_if #(
  parameter int unsigned NSHARES = 6,
  parameter int unsigned WIDTH   = 1
);
  logic [31:0]                port_seed;
  logic                       port_seed_valid;
  logic                       port_seed_ready;
  logic [WIDTH-1:0]           port_x;
  logic                       port_x_valid;
  logic                       port_x_ready;
  logic [NSHARES*WIDTH-1:0]   port_c;
  logic                       port_c_valid;
  logic                       port_c_ready;

  modport slave (
    input  port_seed, port_seed_valid, port_x, port_x_valid, port_c_ready,
    output port_seed_ready, port_x_ready, port_c, port_c_valid
  );

  modport master (
    output port_seed, port_seed_valid, port_x, port_x_valid, port_c_ready,
    input  port_seed_ready, port_x_ready, port_c, port_c_valid
  );
endinterface

// File: rtl/mask_share_encoder.sv
// Splits an unmasked value into NSHARES Boolean shares using masks drawn one bit
// per cycle from a seeded 32-bit Fibonacci LFSR (x^32+x^22+x^2+x+1).
module mask_share_encoder #(
  parameter int unsigned NSHARES = 6,
  parameter int unsigned WIDTH   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mask_share_encoder_if.slave  bus
);

  localparam int unsigned NR = (NSHARES - 1) * WIDTH;
  localparam int unsigned CW = $clog2(NR + 1);

  typedef enum logic [1:0] {UNSEEDED, READY, GEN, OUT} state_t;

  state_t                   state;
  logic [31:0]              lfsr;
  logic [31:0]              seed_eff;
  logic                     fb;
  logic [WIDTH-1:0]         x_reg;
  logic [NR-1:0]            rand_reg;
  logic [NR-1:0]            rand_next;
  logic [CW-1:0]            cnt;
  logic [NSHARES*WIDTH-1:0] shares_next;

  assign fb       = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
  // A zero seed would lock the LFSR, so it is promoted to 1.
  assign seed_eff = (bus.port_seed == '0) ? 32'h0000_0001 : bus.port_seed;

  // Shares are formed from the mask vector including the bit drawn this cycle,
  // so the last GEN edge can register the complete output.
  always_comb begin
    logic [WIDTH-1:0] acc;
    rand_next = rand_reg;
    for (int unsigned i = 0; i < NR; i++) begin
      if (cnt == CW'(i)) rand_next[i] = fb;
    end
    shares_next = '0;
    acc = x_reg;
    for (int unsigned i = 1; i < NSHARES; i++) begin
      shares_next[i*WIDTH +: WIDTH] = rand_next[(i-1)*WIDTH +: WIDTH];
      acc = acc ^ rand_next[(i-1)*WIDTH +: WIDTH];
    end
    shares_next[0 +: WIDTH] = acc;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state               <= UNSEEDED;
      lfsr                <= '0;
      x_reg               <= '0;
      rand_reg            <= '0;
      cnt                 <= '0;
      bus.port_c          <= '0;
      bus.port_c_valid    <= 1'b0;
      bus.port_x_ready    <= 1'b0;
      bus.port_seed_ready <= 1'b1;
    end else begin
      case (state)
        UNSEEDED: begin
          if (bus.port_seed_valid) begin
            lfsr             <= seed_eff;
            state            <= READY;
            bus.port_x_ready <= 1'b1;
          end
        end
        READY: begin
          if (bus.port_seed_valid) lfsr <= seed_eff;
          if (bus.port_x_valid) begin
            x_reg               <= bus.port_x;
            rand_reg            <= '0;
            cnt                 <= '0;
            state               <= GEN;
            bus.port_x_ready    <= 1'b0;
            bus.port_seed_ready <= 1'b0;
          end
        end
        GEN: begin
          lfsr     <= {lfsr[30:0], fb};
          rand_reg <= rand_next;
          cnt      <= cnt + 1'b1;
          if (cnt == CW'(NR - 1)) begin
            bus.port_c       <= shares_next;
            bus.port_c_valid <= 1'b1;
            state            <= OUT;
          end
        end
        OUT: begin
          if (bus.port_c_ready) begin
            bus.port_c_valid    <= 1'b0;
            bus.port_x_ready    <= 1'b1;
            bus.port_seed_ready <= 1'b1;
            state               <= READY;
          end
        end
        default: state <= UNSEEDED;
      endcase
    end
  end

endmodule

// File: tb/tb_mask_share_encoder.sv
// Self-checking bench for mask_share_encoder: directed scenarios plus randomized
// encodings compared against a behavioural LFSR/share model.
module tb_mask_share_encoder;

  localparam int unsigned NS = 6;
  localparam int unsigned W  = 1;
  localparam int unsigned NR = (NS - 1) * W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  logic [31:0] m_lfsr = '0;

  mask_share_encoder_if #(.NSHARES(NS), .WIDTH(W)) bus ();

  mask_share_encoder #(.NSHARES(NS), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: draw NR bits from the polynomial, share i = bit group i-1,
  // share 0 = x XOR all masks.
  task automatic model_encode(input logic [W-1:0] x, output logic [NS*W-1:0] c);
    logic bits[$];
    logic [W-1:0] s0;
    logic [31:0] s;
    s = m_lfsr;
    for (int k = 0; k < int'(NR); k++) begin
      logic b;
      b = s[31] ^ s[21] ^ s[1] ^ s[0];
      bits.push_back(b);
      s = (s << 1) | 32'(b);
    end
    m_lfsr = s;
    c = '0;
    s0 = x;
    for (int i = 1; i < int'(NS); i++) begin
      logic [W-1:0] sh;
      for (int j = 0; j < int'(W); j++) sh[j] = bits[(i-1)*W + j];
      c[i*W +: W] = sh;
      s0 = s0 ^ sh;
    end
    c[0 +: W] = s0;
  endtask

  function automatic logic [W-1:0] xor_shares(input logic [NS*W-1:0] c);
    logic [W-1:0] r = '0;
    for (int i = 0; i < int'(NS); i++) r = r ^ c[i*W +: W];
    return r;
  endfunction

  task automatic load_seed(input logic [31:0] s);
    chk("seed_ready_before_load", 64'(bus.port_seed_ready), 64'd1);
    bus.port_seed = s;
    bus.port_seed_valid = 1'b1;
    step();
    bus.port_seed_valid = 1'b0;
    m_lfsr = (s == 32'd0) ? 32'd1 : s;
  endtask

  // One full encoding; optional seed on the accept edge, stall in OUT,
  // and a spurious x offer during GEN.
  task automatic encode(input logic [W-1:0] x, input int stall, input logic with_seed,
                        input logic [31:0] seed, input logic offer_in_gen,
                        output logic [NS*W-1:0] got);
    logic [NS*W-1:0] exp;
    int lat;
    chk("x_ready_before_accept", 64'(bus.port_x_ready), 64'd1);
    bus.port_x = x;
    bus.port_x_valid = 1'b1;
    if (with_seed) begin
      bus.port_seed = seed;
      bus.port_seed_valid = 1'b1;
      m_lfsr = (seed == 32'd0) ? 32'd1 : seed;
    end
    step();
    bus.port_x_valid = offer_in_gen;
    bus.port_x = ~x;
    bus.port_seed_valid = 1'b0;
    model_encode(x, exp);
    lat = 0;
    while (!bus.port_c_valid && lat < 50) begin
      chk("x_ready_in_gen", 64'(bus.port_x_ready), 64'd0);
      chk("seed_ready_in_gen", 64'(bus.port_seed_ready), 64'd0);
      step();
      lat++;
    end
    bus.port_x_valid = 1'b0;
    chk("latency", 64'(lat), 64'(NR));
    chk("shares", 64'(bus.port_c), 64'(exp));
    chk("share_xor", 64'(xor_shares(bus.port_c)), 64'(x));
    got = bus.port_c;
    for (int k = 0; k < stall; k++) begin
      step();
      chk("stall_valid", 64'(bus.port_c_valid), 64'd1);
      chk("stall_data", 64'(bus.port_c), 64'(exp));
      chk("stall_x_ready", 64'(bus.port_x_ready), 64'd0);
    end
    bus.port_c_ready = 1'b1;
    step();
    bus.port_c_ready = 1'b0;
    chk("valid_drop", 64'(bus.port_c_valid), 64'd0);
    chk("ready_after_out", 64'(bus.port_x_ready), 64'd1);
  endtask

  initial begin
    logic [NS*W-1:0] c;
    bus.port_seed = '0;
    bus.port_seed_valid = 1'b0;
    bus.port_x = '0;
    bus.port_x_valid = 1'b0;
    bus.port_c_ready = 1'b0;

    // Reset state and no acceptance while unseeded
    step();
    step();
    chk("rst_c", 64'(bus.port_c), 64'd0);
    chk("rst_c_valid", 64'(bus.port_c_valid), 64'd0);
    chk("rst_x_ready", 64'(bus.port_x_ready), 64'd0);
    chk("rst_seed_ready", 64'(bus.port_seed_ready), 64'd1);
    reset = 1'b1;
    bus.port_x = 1'b1;
    bus.port_x_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("unseeded_x_ready", 64'(bus.port_x_ready), 64'd0);
      chk("unseeded_c_valid", 64'(bus.port_c_valid), 64'd0);
    end
    chk("unseeded_seed_ready", 64'(bus.port_seed_ready), 64'd1);
    bus.port_x_valid = 1'b0;

    // Seed 1, x=1 -> 0x1A
    load_seed(32'h1);
    encode(1'b1, 0, 1'b0, '0, 1'b0, c);
    chk("seed1_known", 64'(c), 64'h1A);

    // Seed 0 behaves as seed 1
    load_seed(32'h0);
    encode(1'b1, 0, 1'b0, '0, 1'b0, c);
    chk("seed0_known", 64'(c), 64'h1A);

    // Stall in OUT then continued stream with x=0
    load_seed(32'h1);
    encode(1'b1, 10, 1'b0, '0, 1'b0, c);
    chk("stall_known", 64'(c), 64'h1A);
    encode(1'b0, 0, 1'b0, '0, 1'b0, c);

    // Seed and x on the same edge; x offered during GEN is ignored
    encode(1'b1, 2, 1'b1, 32'hDEAD_BEEF, 1'b1, c);
    chk("same_edge_xor", 64'(xor_shares(c)), 64'd1);

    // Reset during GEN cycle 3
    load_seed(32'h1);
    bus.port_x = 1'b1;
    bus.port_x_valid = 1'b1;
    step();
    bus.port_x_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("midrst_c_valid", 64'(bus.port_c_valid), 64'd0);
    chk("midrst_x_ready", 64'(bus.port_x_ready), 64'd0);
    chk("midrst_seed_ready", 64'(bus.port_seed_ready), 64'd1);
    load_seed(32'h1);
    encode(1'b1, 0, 1'b0, '0, 1'b0, c);
    chk("midrst_known", 64'(c), 64'h1A);

    // Randomized encodings
    for (int r = 0; r < 20; r++) begin
      logic [31:0] sd;
      int mode;
      sd = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      mode = $urandom_range(0, 2);
      if (mode == 1) load_seed(sd);
      encode(W'($urandom), $urandom_range(0, 3), mode == 2, sd, $urandom_range(0, 1) == 1, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
